// File: rtl/div16by8_iter_pkg.sv
// Shared types and constants for the iterative 16/8 restoring divider.
package div_pkg;

   localparam int DW_DEF = 8;

   // Replicated DW times to form the all-ones quotient/remainder on error.
   localparam logic ERR_FILL_BIT = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/div16by8_iter_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
   import div_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [DW:0]   rem_i,
   input  logic          bit_i,
   input  logic [DW-1:0] div_i,
   output logic [DW:0]   rem_o,
   output logic          q_o
);

   logic [DW:0] shifted;
   logic        unused_rem_msb;

   // The incoming remainder is always below the divisor, so its top bit is zero.
   assign unused_rem_msb = rem_i[DW];

   always_comb begin
      shifted = {rem_i[DW-1:0], bit_i};
      q_o     = (shifted >= {1'b0, div_i});
      rem_o   = q_o ? (shifted - {1'b0, div_i}) : shifted;
   end

endmodule

// File: rtl/div16by8_iter.sv
// Iterative restoring divider, 2*DW-bit dividend over DW-bit divisor, with valid/ready on both sides.
module div16by8_iter
   import div_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [2*DW-1:0] s_dividend,
   input  logic [DW-1:0]   s_divisor,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [DW-1:0]   m_quot,
   output logic [DW-1:0]   m_rem,
   output logic            m_dbz,
   output logic            m_ovf
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   state_e        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [DW-1:0] lo_q, lo_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [DW:0]   rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dbz_q, dbz_d;
   logic          ovf_q, ovf_d;

   logic [DW:0]   step_rem;
   logic          step_bit;

   div_step #(.DW(DW)) u_step (
      .rem_i (rem_q),
      .bit_i (lo_q[DW-1]),
      .div_i (div_q),
      .rem_o (step_rem),
      .q_o   (step_bit)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d = state_q;
      div_d   = div_q;
      lo_d    = lo_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         S_IDLE: begin
            if (s_valid) begin
               div_d   = s_divisor;
               lo_d    = s_dividend[DW-1:0];
               rem_d   = {1'b0, s_dividend[2*DW-1:DW]};
               cnt_d   = CW'(DW - 1);
               quot_d  = '0;
               dbz_d   = (s_divisor == '0);
               ovf_d   = (s_divisor != '0) && (s_dividend[2*DW-1:DW] >= s_divisor);
               if (dbz_d || ovf_d) begin
                  quot_d = {DW{ERR_FILL_BIT}};
                  rem_d  = {1'b0, {DW{ERR_FILL_BIT}}};
               end
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // Error results were fully formed at accept; spend one cycle and present them.
            if (dbz_q || ovf_q) begin
               state_d = S_DONE;
            end else begin
               rem_d  = step_rem;
               quot_d = {quot_q[DW-2:0], step_bit};
               lo_d   = {lo_q[DW-2:0], 1'b0};
               if (cnt_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         S_DONE: begin
            if (m_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: all registers are reset, so a discarded in-flight result never leaks to m_*.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         lo_q    <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         lo_q    <= lo_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign s_ready = (state_q == S_IDLE);
   assign m_valid = (state_q == S_DONE);
   assign m_quot  = quot_q;
   assign m_rem   = rem_q[DW-1:0];
   assign m_dbz   = dbz_q;
   assign m_ovf   = ovf_q;

endmodule

// File: tb/tb_div16by8_iter.sv
// Self-checking bench for div16by8_iter: directed cases plus randomized checks against an arithmetic model.
module tb_div16by8_iter;

   localparam int DW  = 8;
   localparam int MAX = (1 << DW) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            s_valid;
   logic            s_ready;
   logic [2*DW-1:0] s_dividend;
   logic [DW-1:0]   s_divisor;
   logic            m_valid;
   logic            m_ready;
   logic [DW-1:0]   m_quot;
   logic [DW-1:0]   m_rem;
   logic            m_dbz;
   logic            m_ovf;

   int total = 0;
   int bad   = 0;
   int edge_cnt = 0;
   int accept_edge = 0;

   div16by8_iter #(.DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_dividend (s_dividend),
      .s_divisor  (s_divisor),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_quot     (m_quot),
      .m_rem      (m_rem),
      .m_dbz      (m_dbz),
      .m_ovf      (m_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: true quotient and remainder, with the error fill when it cannot be represented.
   task automatic model(input int a, input int b, output int q, output int r,
                        output bit dbz, output bit ovf);
      dbz = 1'b0;
      ovf = 1'b0;
      if (b == 0) begin
         dbz = 1'b1; q = MAX; r = MAX;
      end else if (a / b > MAX) begin
         ovf = 1'b1; q = MAX; r = MAX;
      end else begin
         q = a / b; r = a % b;
      end
   endtask

   task automatic send(input int a, input int b);
      int guard = 0;
      while (!s_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("s_ready_before_send", 32'(s_ready), 1);
      s_valid    = 1'b1;
      s_dividend = (2*DW)'(a);
      s_divisor  = DW'(b);
      @(posedge clk); #1;
      accept_edge = edge_cnt;
      s_valid = 1'b0;
      check("s_ready_after_accept", 32'(s_ready), 0);
   endtask

   task automatic wait_result(input int a, input int b);
      int q, r;
      bit dbz, ovf;
      int guard = 0;
      model(a, b, q, r, dbz, ovf);
      while (!m_valid && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      check($sformatf("m_valid %0d/%0d", a, b), 32'(m_valid), 1);
      check($sformatf("latency %0d/%0d", a, b), edge_cnt - accept_edge, (dbz || ovf) ? 1 : DW);
      check($sformatf("quot %0d/%0d", a, b), 32'(m_quot), q);
      check($sformatf("rem %0d/%0d", a, b), 32'(m_rem), r);
      check($sformatf("dbz %0d/%0d", a, b), 32'(m_dbz), 32'(dbz));
      check($sformatf("ovf %0d/%0d", a, b), 32'(m_ovf), 32'(ovf));
   endtask

   task automatic run_op(input int a, input int b);
      send(a, b);
      wait_result(a, b);
      @(posedge clk); #1;
      check("released_m_valid", 32'(m_valid), 0);
      check("released_s_ready", 32'(s_ready), 1);
   endtask

   initial begin
      int seen;
      rst        = 1'b1;
      s_valid    = 1'b0;
      s_dividend = '0;
      s_divisor  = '0;
      m_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_s_ready", 32'(s_ready), 1);
      check("reset_m_valid", 32'(m_valid), 0);
      check("reset_quot", 32'(m_quot), 0);
      check("reset_rem", 32'(m_rem), 0);
      check("reset_dbz", 32'(m_dbz), 0);
      check("reset_ovf", 32'(m_ovf), 0);
      rst = 1'b0;

      // Back-to-back stream, downstream always ready.
      run_op(65025, 255);
      run_op(10000, 100);
      run_op(600, 7);
      run_op(91, 13);
      run_op(0, 1);

      // Error classes and the largest in-range quotient.
      run_op(1234, 0);
      run_op(256, 1);
      run_op(65535, 200);
      run_op(255, 1);
      run_op(65535, 255);

      // Backpressure: result must hold and a pending operand must wait.
      m_ready = 1'b0;
      send(600, 3);
      wait_result(600, 3);
      s_valid    = 1'b1;
      s_dividend = 16'd50;
      s_divisor  = 8'd5;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("stall_quot", 32'(m_quot), 200);
         check("stall_rem", 32'(m_rem), 0);
         check("stall_s_ready", 32'(s_ready), 0);
         check("stall_m_valid", 32'(m_valid), 1);
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      check("release_m_valid", 32'(m_valid), 0);
      check("release_s_ready", 32'(s_ready), 1);
      @(posedge clk); #1;
      accept_edge = edge_cnt;
      s_valid = 1'b0;
      check("held_operand_accepted", 32'(s_ready), 0);
      wait_result(50, 5);
      @(posedge clk); #1;

      // Reset in the middle of a calculation discards the result.
      send(1000, 9);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midreset_m_valid", 32'(m_valid), 0);
      check("midreset_s_ready", 32'(s_ready), 1);
      check("midreset_quot", 32'(m_quot), 0);
      check("midreset_rem", 32'(m_rem), 0);
      check("midreset_flags", {30'd0, m_dbz, m_ovf}, 0);
      #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (m_valid) seen++;
      end
      check("discarded_result_absent", seen, 0);
      run_op(1000, 9);

      // Products of operand-domain pairs must divide back exactly.
      for (int i = 0; i < 1000; i++) begin
         int a, b;
         a = int'($urandom_range(MAX, 0));
         b = int'($urandom_range(MAX, 1));
         run_op(a * b, b);
      end

      // Fully random dividend/divisor, including errors.
      for (int i = 0; i < 200; i++) begin
         int a, b;
         a = int'($urandom % 65536);
         b = int'($urandom % 256);
         run_op(a, b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
